// File: rtl/irq_ctrl_bamse.sv
// Interrupt controller for the BAMSE port bus: edge capture, W1C pending, mask, and the
// PicoBlaze interrupt/interrupt_ack handshake with a latched priority vector.
module irq_ctrl_bamse #(
    parameter int unsigned NUM_SRC   = 4,
    parameter logic [7:0]  ADDR_PEND = 8'h01,
    parameter logic [7:0]  ADDR_MASK = 8'h02,
    parameter logic [7:0]  ADDR_VEC  = 8'h03
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         address,
    input  logic [7:0]         data_in,
    input  logic               wen,
    input  logic               ren,
    output logic [7:0]         data_out,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e               r_state, w_state_d;
    logic [NUM_SRC-1:0]   r_src_q, r_pend, r_mask;
    logic [NUM_SRC-1:0]   w_edge, w_clr, w_pend_d, w_mask_d, w_elig;
    logic [7:0]           r_vec, w_vec_d;
    logic [7:0]           w_pend8, w_mask8;
    logic [2:0]           w_win;
    logic                 r_int, w_int_d;
    logic                 w_unused;

    // Reads have no side effects and only the low NUM_SRC data bits are stored.
    assign w_unused = ren ^ (^data_in);

    always_comb begin
        w_edge   = irq_src & ~r_src_q;
        w_clr    = (wen && address == ADDR_PEND) ? data_in[NUM_SRC-1:0] : '0;
        w_pend_d = (r_pend & ~w_clr) | w_edge;
        w_mask_d = (wen && address == ADDR_MASK) ? data_in[NUM_SRC-1:0] : r_mask;
        w_elig   = r_pend & r_mask;
        w_pend8  = '0;
        w_pend8[NUM_SRC-1:0] = r_pend;
        w_mask8  = '0;
        w_mask8[NUM_SRC-1:0] = r_mask;
        // Scan from the top so the lowest set index wins.
        w_win    = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_int_d   = r_int;
        w_vec_d   = r_vec;
        case (r_state)
            StIdle: begin
                if (|w_elig) begin
                    w_state_d = StReq;
                    w_int_d   = 1'b1;
                end
            end
            StReq: begin
                if (interrupt_ack) begin
                    w_int_d = 1'b0;
                    if (|w_elig) begin
                        w_vec_d   = {1'b1, 4'b0000, w_win};
                        w_state_d = StService;
                    end else begin
                        w_vec_d   = 8'h00;
                        w_state_d = StIdle;
                    end
                end
            end
            StService: begin
                if (!w_pend8[r_vec[2:0]] || !w_mask8[r_vec[2:0]]) begin
                    w_vec_d[7] = 1'b0;
                    w_state_d  = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_int_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_src_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_vec   <= 8'h00;
            r_int   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_src_q <= irq_src;
            r_pend  <= w_pend_d;
            r_mask  <= w_mask_d;
            r_vec   <= w_vec_d;
            r_int   <= w_int_d;
        end
    end

    assign interrupt = r_int;

    always_comb begin
        data_out = 8'h00;
        if (address == ADDR_PEND)      data_out = w_pend8;
        else if (address == ADDR_MASK) data_out = w_mask8;
        else if (address == ADDR_VEC)  data_out = r_vec;
    end

endmodule

// File: tb/tb_irq_ctrl_bamse.sv
// Scoreboard bench for irq_ctrl_bamse: stimulus pushes expected register/interrupt values,
// a negedge monitor pops and compares them.
module tb_irq_ctrl_bamse;

    localparam logic [7:0] PEND = 8'h01;
    localparam logic [7:0] MASK = 8'h02;
    localparam logic [7:0] VEC  = 8'h03;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_src = '0;
    logic [7:0] address = '0;
    logic [7:0] data_in = '0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] data_out;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;

    typedef struct {
        bit         is_rd;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    logic smp = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    irq_ctrl_bamse #(.NUM_SRC(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_src       (irq_src),
        .address       (address),
        .data_in       (data_in),
        .wen           (wen),
        .ren           (ren),
        .data_out      (data_out),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    always #5 clk = ~clk;

    // Monitor: pops every expectation queued for the current sample cycle.
    always @(negedge clk) begin
        if (smp) begin
            while (sb.size() > 0) begin
                exp_t       e;
                logic [7:0] act;
                e   = sb.pop_front();
                act = e.is_rd ? data_out : {7'b0, interrupt};
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %02h want %02h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        wen     = 1'b1;
        tick();
        wen     = 1'b0;
    endtask

    task automatic exp_rd(input logic [7:0] a, input logic [7:0] v, input string n);
        exp_t e;
        address = a;
        ren     = 1'b1;
        e.is_rd = 1'b1;
        e.exp   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input logic v, input string n);
        exp_t e;
        e.is_rd = 1'b0;
        e.exp   = {7'b0, v};
        e.name  = n;
        sb.push_back(e);
    endtask

    task automatic sample();
        smp = 1'b1;
        tick();
        smp = 1'b0;
        ren = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        #12 rst_n = 1'b1;
        tick();
        // Reset state
        exp_rd(PEND, 8'h00, "rst_pend"); exp_irq(1'b0, "rst_irq"); sample();
        exp_rd(MASK, 8'h00, "rst_mask"); sample();
        exp_rd(VEC, 8'h00, "rst_vec"); sample();
        exp_rd(8'h05, 8'h00, "unmapped"); sample();

        // 1: timer pulse on src0
        wr(MASK, 8'h01);
        exp_rd(MASK, 8'h01, "t1_mask"); sample();
        ack();
        exp_irq(1'b0, "t1_ack_idle_ignored"); sample();
        irq_src = 4'b0001;
        exp_rd(PEND, 8'h00, "t1_pend_pre"); exp_irq(1'b0, "t1_irq_pre"); sample();
        irq_src = 4'b0000;
        exp_rd(PEND, 8'h01, "t1_pend_k"); exp_irq(1'b0, "t1_irq_k"); sample();
        exp_irq(1'b1, "t1_irq_k1"); sample();
        ack();
        exp_irq(1'b0, "t1_irq_acked"); exp_rd(VEC, 8'h80, "t1_vec"); sample();
        wr(VEC, 8'hFF);
        exp_rd(VEC, 8'h80, "t1_vec_ro"); sample();
        wr(PEND, 8'h01);
        exp_rd(PEND, 8'h00, "t1_pend_clr"); sample();
        exp_rd(VEC, 8'h00, "t1_vec_exit"); exp_irq(1'b0, "t1_irq_exit"); sample();
        exp_irq(1'b0, "t1_idle"); sample();

        // 2: simultaneous src1 and src3
        wr(MASK, 8'h0F);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        exp_irq(1'b1, "t2_irq1"); exp_rd(PEND, 8'h0A, "t2_pend"); sample();
        ack();
        exp_rd(VEC, 8'h81, "t2_vec1"); exp_irq(1'b0, "t2_irq_low"); sample();
        wr(PEND, 8'h02);
        tick();
        exp_rd(VEC, 8'h01, "t2_vec_exit"); exp_irq(1'b0, "t2_idle_gap"); sample();
        exp_irq(1'b1, "t2_irq2"); sample();
        ack();
        exp_rd(VEC, 8'h83, "t2_vec2"); sample();
        wr(PEND, 8'h08);
        tick();
        exp_rd(VEC, 8'h03, "t2_vec_exit2"); exp_irq(1'b0, "t2_irq_end"); sample();
        exp_rd(PEND, 8'h00, "t2_pend_end"); sample();

        // 3: masked source still pends
        wr(MASK, 8'h00);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        exp_rd(PEND, 8'h04, "t3_pend"); exp_irq(1'b0, "t3_irq_masked"); sample();
        wr(MASK, 8'h04);
        exp_irq(1'b0, "t3_irq_1clk"); sample();
        exp_irq(1'b1, "t3_irq_2clk"); sample();
        ack();
        exp_rd(VEC, 8'h82, "t3_vec"); sample();
        wr(PEND, 8'h04);
        tick();
        exp_rd(VEC, 8'h02, "t3_vec_exit"); sample();

        // 4: set/clear collision, then a held source
        wr(MASK, 8'h00);
        address = PEND;
        data_in = 8'h01;
        wen     = 1'b1;
        irq_src = 4'b0001;
        tick();
        wen     = 1'b0;
        exp_rd(PEND, 8'h01, "t4_set_wins"); sample();
        wr(PEND, 8'h01);
        repeat (20) tick();
        exp_rd(PEND, 8'h00, "t4_held_once"); exp_irq(1'b0, "t4_irq"); sample();
        irq_src = 4'b0000;
        tick();

        // 5: spurious request
        wr(MASK, 8'h01);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        exp_irq(1'b1, "t5_irq"); sample();
        wr(MASK, 8'h00);
        exp_irq(1'b1, "t5_irq_hold1"); sample();
        exp_irq(1'b1, "t5_irq_hold2"); sample();
        ack();
        exp_irq(1'b0, "t5_irq_ack"); exp_rd(VEC, 8'h00, "t5_vec"); sample();
        exp_irq(1'b0, "t5_idle"); sample();
        wr(PEND, 8'h01);

        // 6: async reset while in REQ
        wr(MASK, 8'h01);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        exp_irq(1'b1, "t6_irq"); sample();
        #2 rst_n = 1'b0;
        exp_irq(1'b0, "t6_rst_irq"); exp_rd(PEND, 8'h00, "t6_rst_pend"); sample();
        exp_rd(MASK, 8'h00, "t6_rst_mask"); sample();
        exp_rd(VEC, 8'h00, "t6_rst_vec"); sample();
        rst_n = 1'b1;
        tick();

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
